// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding and result-mux select codes.
package alu_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_div_t;

    // ALU result multiplexer selects fed by the divider
    localparam logic [3:0] SEL_DIVISION = 4'b0011;
    localparam logic [3:0] SEL_MODULO   = 4'b0100;

endpackage

// File: rtl/divisor_iterativo_if.sv
// Request/result bundle for divisor_iterativo.
// Optional feature macro: DIVISOR_SIGNED_EN adds the con_signo request bit.
// Handshake: the master raises inicio with operands; it is taken only while
// ocupado=0. listo pulses for one cycle when cociente/residuo/div_cero are
// valid; those stay stable until the next accepted inicio. estado mirrors the FSM.
interface divisor_iterativo_if #(parameter int ancho = 32);
    import alu_pkg::*;

    logic             inicio;
    logic [ancho-1:0] dividendo;
    logic [ancho-1:0] divisor;
`ifdef DIVISOR_SIGNED_EN
    logic             con_signo;
`endif
    logic             ocupado;
    logic             listo;
    logic             div_cero;
    logic [ancho-1:0] cociente;
    logic [ancho-1:0] residuo;
    estado_div_t      estado;

`ifdef DIVISOR_SIGNED_EN
    modport master (output inicio, dividendo, divisor, con_signo,
                    input  ocupado, listo, div_cero, cociente, residuo, estado);
    modport slave  (input  inicio, dividendo, divisor, con_signo,
                    output ocupado, listo, div_cero, cociente, residuo, estado);
`else
    modport master (output inicio, dividendo, divisor,
                    input  ocupado, listo, div_cero, cociente, residuo, estado);
    modport slave  (input  inicio, dividendo, divisor,
                    output ocupado, listo, div_cero, cociente, residuo, estado);
`endif

endinterface

// File: rtl/divisor_paso.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, compare against the divisor on ancho+1 bits, subtract if it fits.
module divisor_paso #(parameter int ancho = 32) (
    input  logic [ancho-1:0] r_in,
    input  logic [ancho-1:0] q_in,
    input  logic [ancho-1:0] d,
    output logic [ancho-1:0] r_out,
    output logic [ancho-1:0] q_out
);

    logic [ancho:0] r_sh;
    logic [ancho:0] resta;

    // Shift, trial subtract and select; the borrow bit decides r >= d
    always_comb begin
        r_sh  = {r_in, q_in[ancho-1]};
        resta = r_sh - {1'b0, d};
        if (!resta[ancho]) begin
            r_out = resta[ancho-1:0];
            q_out = {q_in[ancho-2:0], 1'b1};
        end else begin
            r_out = r_sh[ancho-1:0];
            q_out = {q_in[ancho-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divisor_iterativo.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional feature macro: DIVISOR_SIGNED_EN enables two's-complement mode
// selected per request by con_signo (magnitudes divided, signs fixed on DONE entry).
module divisor_iterativo
    import alu_pkg::*;
#(
    parameter int ancho = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    divisor_iterativo_if.slave   bus
);

    localparam int              cw     = $clog2(ancho);
    localparam logic [cw-1:0]   ultimo = cw'(ancho - 1);

    estado_div_t      estado;
    logic [cw-1:0]    cuenta;
    logic [ancho-1:0] r, q, d;
    logic [ancho-1:0] r_sig, q_sig;
    logic [ancho-1:0] a_mag, b_mag;
    logic [ancho-1:0] q_fin, r_fin;
    logic [ancho-1:0] cociente, residuo;
    logic             div_cero;

    divisor_paso #(.ancho(ancho)) u_paso (
        .r_in  (r),
        .q_in  (q),
        .d     (d),
        .r_out (r_sig),
        .q_out (q_sig)
    );

`ifdef DIVISOR_SIGNED_EN
    logic a_neg, b_neg, neg_q, neg_r;

    // Operand magnitudes and the result signs they imply
    always_comb begin
        a_neg = bus.con_signo & bus.dividendo[ancho-1];
        b_neg = bus.con_signo & bus.divisor[ancho-1];
        a_mag = a_neg ? -bus.dividendo : bus.dividendo;
        b_mag = b_neg ? -bus.divisor   : bus.divisor;
        q_fin = neg_q ? -q_sig : q_sig;
        r_fin = neg_r ? -r_sig : r_sig;
    end

    // Remember result signs for the fix-up at DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (estado == IDLE && bus.inicio) begin
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end
    end
`else
    // Unsigned build: operands and results pass straight through
    always_comb begin
        a_mag = bus.dividendo;
        b_mag = bus.divisor;
        q_fin = q_sig;
        r_fin = r_sig;
    end
`endif

    // Control FSM, iteration datapath and held result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= IDLE;
            cuenta   <= '0;
            r        <= '0;
            q        <= '0;
            d        <= '0;
            cociente <= '0;
            residuo  <= '0;
            div_cero <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (bus.inicio) begin
                        if (bus.divisor == '0) begin
                            // Zero divisor skips iteration entirely
                            estado   <= DONE;
                            cociente <= '1;
                            residuo  <= bus.dividendo;
                            div_cero <= 1'b1;
                        end else begin
                            estado <= CALC;
                            cuenta <= '0;
                            r      <= '0;
                            q      <= a_mag;
                            d      <= b_mag;
                        end
                    end
                end
                CALC: begin
                    r      <= r_sig;
                    q      <= q_sig;
                    cuenta <= cuenta + 1'b1;
                    if (cuenta == ultimo) begin
                        estado   <= DONE;
                        cociente <= q_fin;
                        residuo  <= r_fin;
                        div_cero <= 1'b0;
                    end
                end
                DONE:    estado <= IDLE;
                default: estado <= IDLE;
            endcase
        end
    end

    assign bus.ocupado  = (estado != IDLE);
    assign bus.listo    = (estado == DONE);
    assign bus.div_cero = div_cero;
    assign bus.cociente = cociente;
    assign bus.residuo  = residuo;
    assign bus.estado   = estado;

endmodule
